// File: rtl/mini_core_accel_pkg.sv
// Shared types and defaults for the multiplier arbiter slice.
package mini_core_accel_pkg;

  localparam int NUM_REQ_DEF     = 4;
  localparam int MUL_LATENCY_DEF = 4;
  // Requester id width; holds ids for up to 16 requesters.
  localparam int ID_W            = 4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACTIVE,
    ST_DRAIN
  } arb_state_e;

  typedef struct packed {
    logic            valid;
    logic [ID_W-1:0] id;
  } tag_t;

  function automatic logic [15:0] smul8(input logic [7:0] a, input logic [7:0] b);
    logic signed [15:0] ea;
    logic signed [15:0] eb;
    ea = {{8{a[7]}}, a};
    eb = {{8{b[7]}}, b};
    return ea * eb;
  endfunction

endpackage

// File: rtl/pipe_line_mul.sv
// Fixed-latency pipelined 8x8 signed multiplier; ready marks the result cycle.
module pipe_line_mul
  import mini_core_accel_pkg::*;
#(
  parameter int LATENCY = MUL_LATENCY_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [7:0]  multiplier,
  input  logic [7:0]  multiplicand,
  output logic        ready,
  output logic [15:0] result
);

  logic        vld_q  [LATENCY];
  logic [15:0] prod_q [LATENCY];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned s = 0; s < LATENCY; s++) begin
        vld_q[s]  <= 1'b0;
        prod_q[s] <= '0;
      end
    end else begin
      vld_q[0]  <= start;
      prod_q[0] <= start ? smul8(multiplier, multiplicand) : '0;
      for (int unsigned s = 1; s < LATENCY; s++) begin
        vld_q[s]  <= vld_q[s-1];
        prod_q[s] <= prod_q[s-1];
      end
    end
  end

  assign ready  = vld_q[LATENCY-1];
  assign result = prod_q[LATENCY-1];

endmodule

// File: rtl/pipe_line_mul_arb.sv
// Round-robin arbiter sharing one pipelined multiplier among NUM_REQ requesters.
module pipe_line_mul_arb
  import mini_core_accel_pkg::*;
#(
  parameter int NUM_REQ     = NUM_REQ_DEF,
  parameter int MUL_LATENCY = MUL_LATENCY_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [NUM_REQ*8-1:0] req_multiplier,
  input  logic [NUM_REQ*8-1:0] req_multiplicand,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic [NUM_REQ-1:0]   rsp_valid,
  output logic [15:0]          rsp_result,
  output logic                 idle
);

  localparam int CNT_W = $clog2(MUL_LATENCY + 1);

  arb_state_e      state;
  logic [ID_W-1:0] rr_ptr;
  logic [ID_W-1:0] next_ptr;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_next;
  tag_t            tag_q [MUL_LATENCY];
  tag_t            exit_tag;

  logic            grant_ok;
  logic            grant_vld;
  logic [ID_W-1:0] grant_id;
  int unsigned     pos;

  logic [7:0]      mul_a;
  logic [7:0]      mul_b;
  logic            mul_ready;
  logic [15:0]     mul_result;

  // Grant gated by rst so req_ready stays low while reset is held.
  assign grant_ok = rst && en && (state == ST_IDLE || state == ST_ACTIVE);
  assign exit_tag = tag_q[MUL_LATENCY-1];

  always_comb begin
    grant_vld = 1'b0;
    grant_id  = '0;
    pos       = 0;
    if (grant_ok) begin
      for (int unsigned off = 0; off < NUM_REQ; off++) begin
        pos = int'(rr_ptr) + off;
        if (pos >= int'(NUM_REQ)) pos = pos - NUM_REQ;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
          if (!grant_vld && req_valid[i] && pos == i) begin
            grant_vld = 1'b1;
            grant_id  = ID_W'(i);
          end
        end
      end
    end
  end

  always_comb begin
    next_ptr = (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;
    cnt_next = cnt;
    if (grant_vld && !exit_tag.valid)      cnt_next = cnt + 1'b1;
    else if (!grant_vld && exit_tag.valid) cnt_next = cnt - 1'b1;
  end

  always_comb begin
    mul_a      = '0;
    mul_b      = '0;
    req_ready  = '0;
    rsp_valid  = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      req_ready[i] = grant_vld && (grant_id == ID_W'(i));
      rsp_valid[i] = exit_tag.valid && (exit_tag.id == ID_W'(i));
      if (grant_vld && grant_id == ID_W'(i)) begin
        mul_a = req_multiplier[i*8 +: 8];
        mul_b = req_multiplicand[i*8 +: 8];
      end
    end
    rsp_result = exit_tag.valid ? mul_result : '0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned s = 0; s < MUL_LATENCY; s++) tag_q[s] <= '0;
    end else begin
      tag_q[0] <= '{valid: grant_vld, id: grant_id};
      for (int unsigned s = 1; s < MUL_LATENCY; s++) tag_q[s] <= tag_q[s-1];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= ST_IDLE;
      rr_ptr <= '0;
      cnt    <= '0;
    end else begin
      cnt <= cnt_next;
      if (grant_vld) rr_ptr <= next_ptr;
      case (state)
        ST_IDLE:
          if (en && |req_valid) state <= ST_ACTIVE;
        ST_ACTIVE:
          if (!en && cnt != '0)
            state <= ST_DRAIN;
          else if (cnt == '0 && (!(|req_valid) || !en))
            state <= ST_IDLE;
        ST_DRAIN:
          if (cnt_next == '0) state <= ST_IDLE;
        default:
          state <= ST_IDLE;
      endcase
    end
  end

  assign idle = (state == ST_IDLE) && (cnt == '0);

  pipe_line_mul #(
    .LATENCY(MUL_LATENCY)
  ) u_mul (
    .clk          (clk),
    .rst          (rst),
    .start        (grant_vld),
    .multiplier   (mul_a),
    .multiplicand (mul_b),
    .ready        (mul_ready),
    .result       (mul_result)
  );

  a_ready_matches_tag: assert property (
    @(posedge clk) disable iff (!rst) mul_ready == exit_tag.valid
  );

endmodule
